// File: rtl/cc_bank_pkg.sv
// Shared types and sizing helpers for the cache data bank port controller.
package cc_bank_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } bank_req_t;

  // Width needed to count 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cc_bank_port_ctrl_if.sv
// Request and response channels between a requester and the bank port controller.
interface cc_bank_port_ctrl_if
  import cc_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, busy
  );

endinterface

// File: rtl/cc_bank_resp_fifo.sv
// Small circular FIFO holding bank read data until the consumer takes it.
module cc_bank_resp_fifo
  import cc_bank_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 3,
  localparam int OCC_W  = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [OCC_W-1:0]  o_occ,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [OCC_W-1:0]  r_occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rptr];

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(i_push && r_occ == OCC_W'(DEPTH))
  );

endmodule

// File: rtl/cc_bank_port_ctrl.sv
// Issues read/write requests to a single-port data bank in order and returns
// read data through a credit-protected response FIFO.
module cc_bank_port_ctrl
  import cc_bank_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RESP_DEPTH = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  cc_bank_port_ctrl_if.slave  bus,
  output logic                sram_clk,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int             OCC_W   = occ_w(RESP_DEPTH);
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(RESP_DEPTH);

  logic              r_active;
  logic              r_inflight;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_head;
  logic [OCC_W:0]    w_claimed;
  logic              w_credit_ok;
  logic              w_fire;
  logic              w_resp_valid;
  logic              w_pop;

  // Credit counts only registered state, so a pop never feeds req_ready in the same cycle.
  assign w_claimed    = {1'b0, w_occ} + (OCC_W + 1)'(r_inflight);
  assign w_credit_ok  = (w_claimed < DEPTH_C);
  assign bus.req_ready = r_active & (bus.req_write | w_credit_ok);
  assign w_fire       = bus.req_valid & bus.req_ready;

  assign sram_clk   = clock;
  assign sram_en    = w_fire;
  assign sram_wmode = bus.req_write;
  assign sram_addr  = bus.req_addr;
  assign sram_wdata = bus.req_wdata;

  assign w_resp_valid   = (w_occ != '0);
  assign w_pop          = w_resp_valid & bus.resp_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = w_head;
  assign bus.busy       = r_inflight | w_resp_valid;

  // r_active keeps req_ready low while reset is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_active   <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      r_inflight <= w_fire & ~bus.req_write;
    end
  end

  cc_bank_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clock),
    .rst_n       (reset_n),
    .i_push      (r_inflight),
    .i_push_data (sram_rdata),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

endmodule

// File: tb/tb_cc_bank_port_ctrl.sv
// Directed bench for cc_bank_port_ctrl with a behavioural single-port bank model.
module tb_cc_bank_port_ctrl;

  localparam logic [63:0] PAT  = 64'h0123_4567_0000_0000;
  localparam logic [63:0] D1   = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  cc_bank_port_ctrl_if #(.ADDR_W(14), .DATA_W(64)) bus();

  logic        sram_clk;
  logic        sram_en;
  logic        sram_wmode;
  logic [13:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  cc_bank_port_ctrl #(
    .ADDR_W     (14),
    .DATA_W     (64),
    .RESP_DEPTH (3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .sram_clk   (sram_clk),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Bank macro: one-cycle read latency, write-only-on-enable.
  logic [63:0] mem [0:16383];
  always @(posedge sram_clk) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    logic        v;
    logic        w;
    logic [13:0] a;
    logic [63:0] d;
    logic        rr;
    logic        e_rdy;
    logic        e_en;
    logic        e_wm;
    logic        e_rv;
    logic [63:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(input logic v, w, input logic [13:0] a, input logic [63:0] d,
                              input logic rr, e_rdy, e_en, e_wm, e_rv,
                              input logic [63:0] e_rdata, input logic e_busy);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr;
    t.e_rdy = e_rdy; t.e_en = e_en; t.e_wm = e_wm; t.e_rv = e_rv;
    t.e_rdata = e_rdata; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, w, input logic [13:0] a, input logic [63:0] d, input logic rr);
    @(posedge clock);
    #1;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.resp_ready = rr;
    @(negedge clock);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 8; i++) mem[i] = PAT | 64'(i);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    #1 reset_n = 1'b0;
    #1;
    chk("rst_req_ready",  bus.req_ready,  1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_busy",       bus.busy,       1'b0);
    chk("rst_sram_en",    sram_en,        1'b0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // streaming reads 0..7
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, 14'(i), 0, 1, 1, 1, 0, i >= 2, (i >= 2) ? (PAT | 64'(i - 2)) : 64'h0, i >= 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, PAT | 64'd6, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, PAT | 64'd7, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // write then read same address
    tbl.push_back(mk(1, 1, 14'h0005, D1, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 14'h0005, 0,  1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, D1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0));
    // address extremes
    tbl.push_back(mk(1, 1, 14'h3FFF, ONES, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 14'h0000, 0,    1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 14'h3FFF, 0,    1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 14'h0000, 0,    1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, ONES, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 0,    1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,    0));
    // alternating write/read at 0x0100
    tbl.push_back(mk(1, 1, 14'h0100, 64'd1, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 14'h0100, 0,     1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 14'h0100, 64'd2, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 14'h0100, 0,     1, 1, 1, 0, 1, 64'd1, 1));
    tbl.push_back(mk(1, 1, 14'h0100, 64'd3, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 14'h0100, 0,     1, 1, 1, 0, 1, 64'd2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,     1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 64'd3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,     0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr);
      chk($sformatf("v%0d_req_ready", i), bus.req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_sram_en", i), sram_en, tbl[i].e_en);
      if (tbl[i].e_en) chk($sformatf("v%0d_sram_wmode", i), sram_wmode, tbl[i].e_wm);
      chk($sformatf("v%0d_resp_valid", i), bus.resp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("v%0d_resp_rdata", i), bus.resp_rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].e_busy);
    end

    // backpressure: five reads offered, only three credits
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 14'(1 + acc), 0, 0);
      chk($sformatf("bp%0d_req_ready", k), bus.req_ready, k < 3);
      chk($sformatf("bp%0d_sram_en", k), sram_en, k < 3);
      if (bus.req_ready) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    drive(1, 1, 14'h0200, 64'h55, 0);
    chk("bp_wr_ready", bus.req_ready, 1'b1);
    chk("bp_wr_en",    sram_en,       1'b1);
    chk("bp_wr_wmode", sram_wmode,    1'b1);
    chk("bp_wr_addr",  64'(sram_addr), 64'h0200);
    drive(0, 0, 0, 0, 0);
    chk("bp_hold0_valid", bus.resp_valid, 1'b1);
    chk("bp_hold0_rdata", bus.resp_rdata, PAT | 64'd1);
    chk("bp_hold0_rdy",   bus.req_ready,  1'b0);
    drive(0, 0, 0, 0, 0);
    chk("bp_hold1_rdata", bus.resp_rdata, PAT | 64'd1);
    drive(0, 0, 0, 0, 1);
    chk("bp_pop0_rdata", bus.resp_rdata, PAT | 64'd1);
    chk("bp_pop0_rdy",   bus.req_ready,  1'b0);
    drive(0, 0, 0, 0, 1);
    chk("bp_pop1_rdata", bus.resp_rdata, PAT | 64'd2);
    chk("bp_pop1_rdy",   bus.req_ready,  1'b1);
    drive(0, 0, 0, 0, 1);
    chk("bp_pop2_valid", bus.resp_valid, 1'b1);
    chk("bp_pop2_rdata", bus.resp_rdata, PAT | 64'd3);
    drive(0, 0, 0, 0, 1);
    chk("bp_drained_valid", bus.resp_valid, 1'b0);
    chk("bp_drained_busy",  bus.busy,       1'b0);

    // reset with one read in flight and two buffered
    drive(1, 0, 14'd1, 0, 0);
    drive(1, 0, 14'd2, 0, 0);
    drive(1, 0, 14'd3, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_valid", bus.resp_valid, 1'b1);
    chk("pre_rst_busy",  bus.busy,       1'b1);
    #1;
    reset_n = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    chk("mid_rst_valid", bus.resp_valid, 1'b0);
    chk("mid_rst_busy",  bus.busy,       1'b0);
    chk("mid_rst_ready", bus.req_ready,  1'b0);
    chk("mid_rst_en",    sram_en,        1'b0);
    #1;
    reset_n = 1'b1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1);
      chk($sformatf("post_rst%0d_valid", k), bus.resp_valid, 1'b0);
      chk($sformatf("post_rst%0d_busy", k),  bus.busy,       1'b0);
    end
    drive(1, 0, 14'd2, 0, 1);
    chk("post_rst_rd_ready", bus.req_ready, 1'b1);
    drive(0, 0, 0, 0, 1);
    chk("post_rst_rd_t1_valid", bus.resp_valid, 1'b0);
    chk("post_rst_rd_t1_busy",  bus.busy,       1'b1);
    drive(0, 0, 0, 0, 1);
    chk("post_rst_rd_t2_valid", bus.resp_valid, 1'b1);
    chk("post_rst_rd_t2_rdata", bus.resp_rdata, PAT | 64'd2);
    drive(0, 0, 0, 0, 1);
    chk("post_rst_rd_t3_valid", bus.resp_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
